// File: rtl/cmp_pkg.sv
// Shared types and constants for the sequential chunked comparator.
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Index register width; a single-chunk build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Unsigned magnitude compare of one CHUNK-bit slice.
module chunk_cmp #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (a < b);
    assign eq = (a == b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_comparator.sv
// Multi-cycle comparator: walks the captured operands one slice per cycle,
// MSB slice first, and stops at the first slice that differs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for en_in; operands and mode captured on start
// RUN     | comparing slice idx; leaves on first difference or last slice
// DONE    | one-cycle done_out pulse, results already on the outputs
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             en_in,
    input  logic             mode_in,
    output logic [WIDTH-1:0] y_out,
    output logic             carry,
    output logic             zero,
    output logic             busy_out,
    output logic             done_out
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    generate
        if (WIDTH < 2) begin : g_bad_width
            $error("seq_comparator: WIDTH must be at least 2");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_comparator: CHUNK must be positive and divide WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, b_q;
    logic               mode_q;
    logic               capture, finish;

    logic [WIDTH-1:0]   a_op, b_op;
    logic [CHUNK-1:0]   a_sl, b_sl;
    logic               sl_lt, sl_eq, sl_gt;
    logic               last_slice;

    // Flipping the sign bit of both operands maps two's-complement order
    // onto unsigned order, so the slice compare stays unsigned.
    assign a_op = (mode_q == MODE_SIGNED) ? (a_q ^ MSB_MASK) : a_q;
    assign b_op = (mode_q == MODE_SIGNED) ? (b_q ^ MSB_MASK) : b_q;

    assign a_sl = CHUNK'(a_op >> (CHUNK * (NCHUNK - 1 - int'(idx_q))));
    assign b_sl = CHUNK'(b_op >> (CHUNK * (NCHUNK - 1 - int'(idx_q))));

    assign last_slice = (idx_q == IDX_W'(NCHUNK - 1));

    chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
        .a  (a_sl),
        .b  (b_sl),
        .lt (sl_lt),
        .eq (sl_eq),
        .gt (sl_gt)
    );

    // Next-state, slice index and capture/finish strobes.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_in) begin
                    capture = 1'b1;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (sl_lt || sl_gt || last_slice) begin
                    finish  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with registered status flags derived from the next state.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            busy_out <= (state_d == ST_RUN);
            done_out <= (state_d == ST_DONE);
        end
    end

    // Operand and mode capture at start.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a_q    <= '0;
            b_q    <= '0;
            mode_q <= MODE_UNSIGNED;
        end else if (capture) begin
            a_q    <= a_in;
            b_q    <= b_in;
            mode_q <= mode_in;
        end
    end

    // Result registers, loaded on the edge that enters DONE and held after.
    // Reaching finish with an equal slice means every slice matched.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            y_out <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (finish) begin
            y_out <= sl_lt ? b_q : a_q;
            carry <= sl_lt;
            zero  <= sl_eq;
        end
    end

endmodule
